// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the single memory/L2 line port between the
// I-cache and D-cache miss paths. Requests are granted round-robin and the
// winner's command is registered onto the memory port. Completion pulses
// and read data are routed only to the side currently being served.
module l2_mem_arbiter #(
    parameter int addr_width = 16,
    parameter int line_width = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [addr_width-1:0] i_address,
    output logic                  i_resp,
    output logic [line_width-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [addr_width-1:0] d_address,
    input  logic [line_width-1:0] d_wdata,
    output logic                  d_resp,
    output logic [line_width-1:0] d_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [addr_width-1:0] mem_address,
    output logic [line_width-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [line_width-1:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0] state;
    logic       last_grant;   // 0 = I was served last, 1 = D was served last
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    // Round-robin pick: a lone requester wins, a tie goes to the side not served last
    always_comb begin
        d_req   = d_read | d_write;
        grant_d = d_req && (!i_read || !last_grant);
        grant_i = i_read && !grant_d;
    end

    // Arbitration FSM and the registered memory command; a D write beats a D read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        last_grant  <= 1'b1;
                        mem_address <= d_address;
                        mem_write   <= d_write;
                        mem_read    <= d_read & ~d_write;
                        mem_wdata   <= d_wdata;
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        last_grant  <= 1'b0;
                        mem_address <= i_address;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Route the memory completion only to the side being served; data is zero otherwise
    always_comb begin
        i_resp  = (state == SERVE_I) && mem_resp;
        d_resp  = (state == SERVE_D) && mem_resp;
        i_rdata = i_resp ? mem_rdata : '0;
        d_rdata = d_resp ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: directed scenarios with literal expectations, then a
// randomized run of both requesters and a memory with random latency, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_l2_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    l2_mem_arbiter #(.addr_width(AW), .line_width(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Transaction-level model: who owns the memory port and what command it carries
    int            m_owner = 0;      // 0 = nobody, 1 = I-cache, 2 = D-cache
    int            m_last = 1;       // side served last (1 = I, 2 = D)
    logic          m_rd = 1'b0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    logic          exp_i_resp;
    logic          exp_d_resp;
    logic [LW-1:0] exp_i_rdata;
    logic [LW-1:0] exp_d_rdata;

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each edge; reset abandons whatever was in flight
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_last = 1; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (m_owner == 0) begin
            bit want_i;
            bit want_d;
            want_i = i_read;
            want_d = d_read || d_write;
            if (want_i && want_d) m_owner = (m_last == 1) ? 2 : 1;
            else if (want_d)      m_owner = 2;
            else if (want_i)      m_owner = 1;
            if (m_owner == 2) begin
                m_addr = d_address; m_wdata = d_wdata; m_wr = d_write; m_rd = d_read && !d_write;
            end else if (m_owner == 1) begin
                m_addr = i_address; m_wdata = '0; m_wr = 1'b0; m_rd = 1'b1;
            end
            if (m_owner != 0) m_last = m_owner;
        end else if (mem_resp) begin
            m_owner = 0; m_rd = 1'b0; m_wr = 1'b0;
        end
    end

    // Expected completion outputs follow the owner and this cycle's memory pulse
    always_comb begin
        exp_i_resp  = (m_owner == 1) && mem_resp;
        exp_d_resp  = (m_owner == 2) && mem_resp;
        exp_i_rdata = exp_i_resp ? mem_rdata : '0;
        exp_d_rdata = exp_d_resp ? mem_rdata : '0;
    end

    // Compare every DUT output against the model in the middle of each cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("mdl mem_read", LW'(mem_read), LW'(m_rd));
            checkOutput("mdl mem_write", LW'(mem_write), LW'(m_wr));
            checkOutput("mdl mem_address", LW'(mem_address), LW'(m_addr));
            checkOutput("mdl mem_wdata", mem_wdata, m_wdata);
            checkOutput("mdl i_resp", LW'(i_resp), LW'(exp_i_resp));
            checkOutput("mdl i_rdata", i_rdata, exp_i_rdata);
            checkOutput("mdl d_resp", LW'(d_resp), LW'(exp_d_resp));
            checkOutput("mdl d_rdata", d_rdata, exp_d_rdata);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem_read", LW'(mem_read), '0);
        checkOutput("reset mem_address", LW'(mem_address), '0);
        checkOutput("reset mem_wdata", mem_wdata, '0);
        rst_n = 1'b1;
    endtask

    // Random requesters and a memory with 0..3 cycles of extra latency plus stray pulses
    task automatic applyStimulus(input int cycles);
        bit i_done = 1'b0;
        bit d_done = 1'b0;
        bit was_serving = 1'b0;
        int delay = 0;
        int kind;
        for (int c = 0; c < cycles; c++) begin
            if (i_done) i_read = 1'b0;
            else if (!i_read && $urandom_range(3) == 0) begin
                i_read = 1'b1; i_address = AW'($urandom);
            end
            if (m_owner == 1) i_address = AW'($urandom);
            if (d_done) begin
                d_read = 1'b0; d_write = 1'b0;
            end else if (!d_read && !d_write && $urandom_range(3) == 0) begin
                kind = $urandom_range(2);
                d_read = (kind != 1); d_write = (kind != 0);
                d_address = AW'($urandom); d_wdata = rand_line();
            end
            if (m_owner == 2) begin
                d_address = AW'($urandom); d_wdata = rand_line();
            end
            mem_rdata = rand_line();
            if (m_owner != 0) begin
                if (!was_serving) delay = $urandom_range(3);
                was_serving = 1'b1;
                if (delay == 0) mem_resp = 1'b1;
                else begin
                    mem_resp = 1'b0; delay--;
                end
            end else begin
                was_serving = 1'b0;
                mem_resp = ($urandom_range(7) == 0);
            end
            @(negedge clk);
            i_done = exp_i_resp;
            d_done = exp_d_resp;
            next_cycle();
        end
    endtask

    initial begin
        logic [LW-1:0] a5_line;
        logic [LW-1:0] beef_line;
        int waited;
        int side;
        a5_line   = {16{8'hA5}};
        beef_line = {4{32'hDEAD_BEEF}};

        #2;
        cmp_en = 1'b1;
        do_reset();

        // I read alone, memory answers three cycles after the command
        i_read = 1'b1; i_address = 16'h1230;
        next_cycle();
        @(negedge clk);
        checkOutput("solo mem_read", LW'(mem_read), LW'(1'b1));
        checkOutput("solo mem_address", LW'(mem_address), LW'(16'h1230));
        checkOutput("solo early i_resp", LW'(i_resp), '0);
        next_cycle();
        next_cycle();
        next_cycle();
        mem_resp = 1'b1; mem_rdata = a5_line;
        @(negedge clk);
        checkOutput("solo i_resp", LW'(i_resp), LW'(1'b1));
        checkOutput("solo i_rdata", i_rdata, a5_line);
        checkOutput("solo d_resp", LW'(d_resp), '0);
        next_cycle();
        i_read = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        checkOutput("solo i_resp one cycle", LW'(i_resp), '0);
        checkOutput("solo mem_read cleared", LW'(mem_read), '0);
        next_cycle();

        // Tie after reset: D first, one idle cycle, then I
        do_reset();
        i_read = 1'b1; i_address = 16'h0100;
        d_read = 1'b1; d_address = 16'h0200;
        next_cycle();
        mem_resp = 1'b1; mem_rdata = rand_line();
        @(negedge clk);
        checkOutput("tie first address", LW'(mem_address), LW'(16'h0200));
        checkOutput("tie d_resp", LW'(d_resp), LW'(1'b1));
        checkOutput("tie i_resp", LW'(i_resp), '0);
        next_cycle();
        d_read = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        checkOutput("tie idle mem_read", LW'(mem_read), '0);
        next_cycle();
        @(negedge clk);
        checkOutput("tie second mem_read", LW'(mem_read), LW'(1'b1));
        checkOutput("tie second address", LW'(mem_address), LW'(16'h0100));
        next_cycle();
        mem_resp = 1'b1;
        next_cycle();
        i_read = 1'b0; mem_resp = 1'b0;
        next_cycle();

        // Continuous requests from both sides: grants alternate D, I, D, I, D, I
        do_reset();
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        for (int n = 0; n < 6; n++) begin
            waited = 0;
            next_cycle();
            while (!mem_read && waited < 10) begin
                next_cycle();
                waited++;
            end
            checkOutput("alternate grant timeout", LW'(waited < 10), LW'(1'b1));
            side = (mem_address == 16'h2222) ? 2 : 1;
            checkOutput("alternate order", LW'(side), LW'((n % 2 == 0) ? 2 : 1));
            mem_resp = 1'b1;
            next_cycle();
            mem_resp = 1'b0;
            if (side == 2) d_read = 1'b0;
            else           i_read = 1'b0;
            next_cycle();
            if (side == 2) d_read = 1'b1;
            else           i_read = 1'b1;
        end
        clear_inputs();
        repeat (3) next_cycle();

        // D writeback with a conflicting read: write wins, data held through service
        do_reset();
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h3FF0; d_wdata = beef_line;
        next_cycle();
        checkOutput("wb mem_write", LW'(mem_write), LW'(1'b1));
        checkOutput("wb mem_read", LW'(mem_read), '0);
        checkOutput("wb mem_wdata", mem_wdata, beef_line);
        d_wdata = ~beef_line; d_address = 16'h0000;
        next_cycle();
        checkOutput("wb wdata held", mem_wdata, beef_line);
        checkOutput("wb address held", LW'(mem_address), LW'(16'h3FF0));
        mem_resp = 1'b1; mem_rdata = rand_line();
        @(negedge clk);
        checkOutput("wb d_resp", LW'(d_resp), LW'(1'b1));
        next_cycle();
        clear_inputs();
        next_cycle();

        // Reset in the middle of an I service clears everything at once
        do_reset();
        i_read = 1'b1; i_address = 16'h0400;
        next_cycle();
        checkOutput("midrst mem_read before", LW'(mem_read), LW'(1'b1));
        #2;
        mem_resp = 1'b1; mem_rdata = {16{8'hFF}};
        rst_n = 1'b0;
        #1;
        checkOutput("midrst mem_read", LW'(mem_read), '0);
        checkOutput("midrst mem_write", LW'(mem_write), '0);
        checkOutput("midrst mem_address", LW'(mem_address), '0);
        checkOutput("midrst mem_wdata", mem_wdata, '0);
        checkOutput("midrst i_resp", LW'(i_resp), '0);
        checkOutput("midrst i_rdata", i_rdata, '0);
        checkOutput("midrst d_resp", LW'(d_resp), '0);
        checkOutput("midrst d_rdata", d_rdata, '0);
        i_read = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checkOutput("midrst late i_resp", LW'(i_resp), '0);
        checkOutput("midrst late d_resp", LW'(d_resp), '0);
        next_cycle();
        mem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h0500;
        d_read = 1'b1; d_address = 16'h0600;
        next_cycle();
        checkOutput("midrst tie address", LW'(mem_address), LW'(16'h0600));
        mem_resp = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();

        // Stray memory pulses while idle: no response, no grant, round-robin pointer kept
        mem_resp = 1'b1; mem_rdata = rand_line();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stray i_resp", LW'(i_resp), '0);
            checkOutput("stray d_resp", LW'(d_resp), '0);
            checkOutput("stray mem_read", LW'(mem_read), '0);
            next_cycle();
        end
        mem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h0700;
        d_read = 1'b1; d_address = 16'h0800;
        next_cycle();
        checkOutput("stray tie address", LW'(mem_address), LW'(16'h0700));
        mem_resp = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();

        // Randomized traffic against the model
        do_reset();
        applyStimulus(3000);
        clear_inputs();
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
